multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared multicycle MIPS datapath: one ALU and one unified memory, reused across cycles.
//  Supports R-type, lw, sw, beq, addi and j, using the same opcode encodings as the single-cycle main decoder.
//  Adds a memory-ready handshake, an illegal-opcode flag and a retired-fetch counter.
// PARAMETERS
//  MEM_HS   1   1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = treat mem_ready as always 1
//  CNT_W    32  width of instr_count
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  op           in   6      opcode from the instruction register
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory has completed the current access this cycle
//  iord         out  1      0 = address is PC; 1 = address is ALUOut
//  memwrite     out  1      memory write strobe
//  irwrite      out  1      instruction register load
//  regdst       out  1      1 = write rd; 0 = write rt
//  memtoreg     out  1      1 = writeback data from memory; 0 = from ALUOut
//  regwrite     out  1      register file write strobe
//  alusrca      out  1      0 = PC; 1 = register A
//  alusrcb      out  2      00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
//  aluop        out  2      00 = add, 01 = sub, 10 = decode funct
//  pcsrc        out  2      00 = ALUResult, 01 = ALUOut, 10 = jump target
//  pcen         out  1      PC load enable
//  illegal_op   out  1      opcode not decoded (valid in DECODE)
//  state        out  4      current state (debug)
//  instr_count  out  CNT_W  count of completed fetches
// BEHAVIOUR
//  State encodings:
//   FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7,
//   BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are unused and go to FETCH next cycle.
//  reset_n=0 (async):
//   - state=FETCH and instr_count=0 immediately.
//   - pcen, irwrite, regwrite and memwrite are forced 0 while reset is held.
//   - All other outputs take their FETCH values.
//  Transitions:
//   - FETCH->DECODE on rdy (rdy = mem_ready | ~MEM_HS); otherwise stay in FETCH.
//   - DECODE branches on op:
//     000000->RTYPEEX, 100011|101011->MEMADR, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, else->FETCH.
//   - MEMADR->MEMRD if op=lw, else ->MEMWR.
//   - MEMRD->MEMWB on rdy; MEMWR->FETCH on rdy; both hold otherwise.
//   - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
//   - RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
//  Outputs are a pure function of state; any signal not listed below is 0.
//   - FETCH:   alusrcb=01, irwrite=rdy, pcwrite=rdy.
//   - DECODE:  alusrcb=11.
//   - MEMADR:  alusrca=1, alusrcb=10.
//   - MEMRD:   iord=1.
//   - MEMWB:   memtoreg=1, regwrite=1.
//   - MEMWR:   iord=1, memwrite=1 (held high for the whole wait).
//   - RTYPEEX: alusrca=1, aluop=10.
//   - RTYPEWB: regdst=1, regwrite=1.
//   - BEQEX:   alusrca=1, aluop=01, pcsrc=01, branch=1.
//   - ADDIEX:  alusrca=1, alusrcb=10.
//   - ADDIWB:  regwrite=1.
//   - JEX:     pcsrc=10, pcwrite=1.
//  pcen = pcwrite | (branch & zero), combinational.
//  illegal_op = (state==DECODE) & (op is not one of the six decoded opcodes), combinational. It is a 1-cycle pulse;
//   the instruction is discarded with no regwrite/memwrite.
//  instr_count increments by 1 on each clock edge where state==FETCH & rdy; wraps modulo 2^CNT_W.
//  CPI (with rdy=1 every cycle):
//   lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, illegal=2.
//   Each cycle of mem_ready=0 adds one cycle.
// TESTING
//  1. mem_ready=1, op=100011 (lw):
//     -> states 0,1,2,3,4,0; regwrite=1 & memtoreg=1 only in cycle 5; instr_count 0->1.
//  2. op=000100 (beq), zero=1:
//     -> pcen=1 in FETCH and in BEQEX, pcsrc=01 in BEQEX.
//     Repeat with zero=0 -> pcen=0 in BEQEX.
//  3. FETCH with mem_ready low for 3 cycles, then high:
//     -> state stays 0 for 4 cycles; irwrite and pcen high only in the 4th; instr_count +1 exactly once.
//  4. op=111111:
//     -> illegal_op=1 only in DECODE; next state FETCH; regwrite and memwrite never asserted.
//  5. sw with mem_ready=0, reset_n dropped mid-MEMWR:
//     -> memwrite falls without waiting for a clock; state=0 and instr_count=0 immediately.
//     After release, normal fetch.
//  6. CNT_W=4, 16 back-to-back j (000010) instructions:
//     -> instr_count reads 15 then wraps to 0; each j takes 3 cycles, with pcsrc=10 and pcen=1 in JEX.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore control FSM for the shared multicycle MIPS datapath
// (single ALU, unified instruction/data memory). Decodes R-type, lw, sw, beq,
// addi and j. Fetch and data accesses wait on a memory-ready handshake.
// Opcodes that are not decoded raise illegal_op for the DECODE cycle, and the
// instruction is then dropped. A counter tracks completed fetches.
//
// Ports
//   clk, reset_n            rising-edge clock, async active-low reset
//   op[5:0]                 opcode from the instruction register
//   zero                    ALU zero flag, used for beq
//   mem_ready               memory finished the current access this cycle
//   iord .. pcsrc           datapath mux selects and write strobes
//   pcen                    PC load enable (jump/fetch, or taken branch)
//   illegal_op              undecoded opcode seen in DECODE
//   state[3:0]              current state, for debug
//   instr_count[CNT_W-1:0]  completed fetches, wraps
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4 when ready
// DECODE  | register read, branch target into ALUOut
// MEMADR  | effective address = A + signext(imm)
// MEMRD   | load read at ALUOut, wait for ready
// MEMWB   | write load data into rt
// MEMWR   | store write at ALUOut, wait for ready
// RTYPEEX | A funct B
// RTYPEWB | write ALUOut into rd
// BEQEX   | A - B, take branch on zero
// ADDIEX  | A + signext(imm)
// ADDIWB  | write ALUOut into rt
// JEX     | PC <= jump target
module multicycle_ctrl #(
  parameter bit MEM_HS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic             rdy;
  logic             pcwrite;
  logic             branch;
  logic             irwrite_s;
  logic             regwrite_s;
  logic             memwrite_s;

  // Without the handshake the memory is assumed single-cycle.
  assign rdy = mem_ready | ~MEM_HS;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && rdy) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = rdy;
        pcwrite   = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        state_d    = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are gated by reset directly so they drop without a clock.
  assign pcen        = reset_n & (pcwrite | (branch & zero));
  assign irwrite     = reset_n & irwrite_s;
  assign regwrite    = reset_n & regwrite_s;
  assign memwrite    = reset_n & memwrite_s;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal_op;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic [31:0] instr_count;

  logic iord4, memwrite4, irwrite4, regdst4, memtoreg4, regwrite4, alusrca4, pcen4, illegal_op4;
  logic [1:0] alusrcb4, aluop4, pcsrc4;
  logic [3:0] state4;
  logic [3:0] instr_count4;

  ctrl_t ctrl, ctrl4;
  assign ctrl  = '{iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, aluop, pcsrc, pcen, illegal_op};
  assign ctrl4 = '{iord4, memwrite4, irwrite4, regdst4, memtoreg4, regwrite4, alusrca4,
                   alusrcb4, aluop4, pcsrc4, pcen4, illegal_op4};

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  multicycle_ctrl #(.MEM_HS(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord4), .memwrite(memwrite4), .irwrite(irwrite4), .regdst(regdst4),
    .memtoreg(memtoreg4), .regwrite(regwrite4), .alusrca(alusrca4), .alusrcb(alusrcb4),
    .aluop(aluop4), .pcsrc(pcsrc4), .pcen(pcen4), .illegal_op(illegal_op4),
    .state(state4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_ADDI || o == OP_J;
  endfunction

  // Expected control word per state, straight from the output table.
  function automatic ctrl_t exp_ctrl(input int st, input logic rdy, input logic z,
                                     input logic [5:0] o);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcen = rdy; end
      1:  begin c.alusrcb = 2'b11; c.illegal_op = !is_legal(o); end
      2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      3:  c.iord = 1'b1;
      4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z; end
      9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      10: c.regwrite = 1'b1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle in which the design is expected to sit in state st.
  // Entered and left 1 time unit after a rising edge.
  task automatic cyc(input int st, input logic rdy, input logic z, input logic [5:0] o);
    mem_ready = rdy;
    zero      = z;
    op        = o;
    @(negedge clk);
    chk("state",  {60'd0, state},  st);
    chk("state4", {60'd0, state4}, st);
    chk("ctrl",   {49'd0, ctrl},   {49'd0, exp_ctrl(st, rdy, z, o)});
    chk("ctrl4",  {49'd0, ctrl4},  {49'd0, exp_ctrl(st, rdy, z, o)});
    chk("count",  {32'd0, instr_count}, {32'd0, cnt});
    chk("count4", {60'd0, instr_count4}, {60'd0, cnt[3:0]});
    @(posedge clk);
    if (st == 0 && rdy) cnt = cnt + 32'd1;
    #1;
  endtask

  // A handshake state: nwait cycles with mem_ready low, then one with it high.
  task automatic mem_step(input int st, input int nwait, input logic z, input logic [5:0] o);
    for (int i = 0; i < nwait; i++) cyc(st, 1'b0, z, o);
    cyc(st, 1'b1, z, o);
  endtask

  // One whole instruction as the path of states its opcode implies.
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm, input logic z);
    logic r;
    r = 1'($urandom_range(0, 1));
    mem_step(0, wf, z, o);
    cyc(1, r, z, o);
    case (o)
      OP_LW:   begin cyc(2, r, z, o); mem_step(3, wm, z, o); cyc(4, r, z, o); end
      OP_SW:   begin cyc(2, r, z, o); mem_step(5, wm, z, o); end
      OP_R:    begin cyc(6, r, z, o); cyc(7, r, z, o); end
      OP_BEQ:  cyc(8, r, z, o);
      OP_ADDI: begin cyc(9, r, z, o); cyc(10, r, z, o); end
      OP_J:    cyc(11, r, z, o);
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    cnt = 32'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_R;
      1: o = OP_LW;
      2: o = OP_SW;
      3: o = OP_BEQ;
      4: o = OP_ADDI;
      5: o = OP_J;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (is_legal(o)) o = 6'($urandom_range(0, 63));
      end
    endcase
    return o;
  endfunction

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Held reset with mem_ready high: FETCH values but no write strobes.
    chk("rst_state", {60'd0, state}, 0);
    chk("rst_ctrl",  {49'd0, ctrl}, {49'd0, exp_ctrl(0, 1'b0, 1'b0, 6'd0)});
    chk("rst_count", {32'd0, instr_count}, 0);
    reset_n = 1'b1;

    run_instr(OP_LW, 0, 0, 1'b0);
    chk("lw_count", {32'd0, instr_count}, 1);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_R, 3, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 2, 1'b0);
    run_instr(OP_ADDI, 1, 0, 1'b1);
    run_instr(OP_J, 0, 0, 1'b0);

    // Reset asserted in the middle of a stalled store.
    mem_step(0, 0, 1'b0, OP_SW);
    cyc(1, 1'b1, 1'b0, OP_SW);
    cyc(2, 1'b1, 1'b0, OP_SW);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_memwrite", {63'd0, memwrite}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_memwrite", {63'd0, memwrite}, 0);
    chk("async_state",    {60'd0, state}, 0);
    chk("async_count",    {32'd0, instr_count}, 0);
    chk("async_count4",   {60'd0, instr_count4}, 0);
    cnt = 32'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_instr(OP_LW, 1, 1, 1'b0);

    // 16 jumps wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0, 1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("wrap_count4", {60'd0, instr_count4}, 0);
    chk("wrap_count",  {32'd0, instr_count}, 16);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      int wf, wm;
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(pick_op(), wf, wm, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
